fetch_sequencer: RTL and testbench

- Front-end controller for the out-of-order CPU.
- Sequences the PC, issues reads to the trace-loaded instruction memory, and buffers returned instructions in a small fetch queue.
- Presents instructions to decode/rename over a valid/ready handshake.
- Handles redirect (flush) and end-of-trace halt, where end-of-trace is an all-zero instruction word.

---
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end fetch controller.
// Sequences the PC, issues single-cycle-latency reads to instruction memory,
// buffers returned instructions in a small FIFO, and presents them to decode
// over a valid/ready handshake. An all-zero instruction word ends the trace.
// Optional feature macro: FETCH_TRACE_EN (simulation-only dequeue/halt trace).
//
// Handshake: a dequeue transfers when deq_valid && deq_ready are both high at
// a rising clock edge; deq_valid never depends on deq_ready, and the head
// entry stays stable until it is accepted or a flush/reset clears the queue.
module fetch_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter int                 FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          flush,
    input  logic [ADDR_W-1:0]             flush_pc,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [31:0]                   deq_instr,
    output logic [ADDR_W-1:0]             deq_pc,
    output logic [$clog2(FQ_DEPTH):0]     fq_count,
    output logic                          halted
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   req_pc;
    logic                inflight;
    logic                discard;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;

    logic [31:0]         instr_q [FQ_DEPTH];
    logic [ADDR_W-1:0]   pc_q    [FQ_DEPTH];

    logic                credit_ok;
    logic                req_fire;
    logic                resp_valid;
    logic                resp_zero;
    logic                enq;
    logic                deq_fire;

    // Request/response/dequeue decode. The credit check counts the response
    // still in flight but not a same-cycle dequeue, so the queue cannot overflow.
    always_comb begin
        credit_ok  = ({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(FQ_DEPTH);
        req_fire   = rst_n && (state == ST_RUN) && !flush && credit_ok;
        resp_valid = rst_n && inflight && !discard;
        resp_zero  = resp_valid && (imem_rdata == 32'h0);
        enq        = resp_valid && (imem_rdata != 32'h0) && !flush;
        deq_valid  = (count != '0);
        deq_fire   = deq_valid && deq_ready;
        imem_req   = req_fire;
        imem_addr  = req_fire ? pc : '0;
        deq_instr  = deq_valid ? instr_q[head] : 32'h0;
        deq_pc     = deq_valid ? pc_q[head] : '0;
        fq_count   = count;
    end

    // Control FSM: PC sequencing, response tracking, queue pointers, halt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted   <= 1'b0;
        end else if (flush) begin
            state    <= ST_RUN;
            pc       <= flush_pc;
            inflight <= 1'b0;
            discard  <= inflight;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted   <= 1'b0;
        end else begin
            inflight <= req_fire;
            // A request racing the end-of-trace word must not enqueue later.
            discard  <= resp_zero && req_fire;
            if (req_fire) begin
                pc     <= pc + ADDR_W'(PC_STEP);
                req_pc <= pc;
            end
            if (resp_zero) begin
                state <= ST_HALT;
            end
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
            case ({enq, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            halted <= (state == ST_HALT) && (count == '0);
        end
    end

    // Queue storage; written at the tail on each accepted response.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail] <= imem_rdata;
            pc_q[tail]    <= req_pc;
        end
    end

`ifdef FETCH_TRACE_EN
    logic halted_q;

    // Simulation trace of dequeues and the halt event.
    always @(posedge clk) begin
        halted_q <= rst_n ? halted : 1'b0;
        if (rst_n && deq_fire) begin
            $display("PC: %d, Instruction: %h", deq_pc, deq_instr);
        end
        if (rst_n && halted && !halted_q) begin
            $display("FETCH HALT");
        end
    end
`else
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer.
// A cycle table covers sequential fetch, halt and flush-from-halt; hand
// sequences cover backpressure, mid-stream flush, mid-run reset and
// toggling-ready wrap traffic.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  fq_count;
    logic        halted;

    int total;
    int bad;

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [31:0] flush_pc;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  count;
        logic        halted;
    } vec_t;

    vec_t vt [15];

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_instr  (deq_instr),
        .deq_pc     (deq_pc),
        .fq_count   (fq_count),
        .halted     (halted)
    );

    // Clock and a hard time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory model: one-cycle read latency.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fpc,
                                input logic rdy, input logic rq, input logic [31:0] ad,
                                input logic v, input logic [31:0] p, input logic [31:0] ins,
                                input logic [2:0] c, input logic h);
        vec_t t;
        t.rst_n = r; t.flush = f; t.flush_pc = fpc; t.ready = rdy;
        t.req = rq; t.addr = ad; t.valid = v; t.pc = p; t.instr = ins;
        t.count = c; t.halted = h;
        return t;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        flush = 1'b0;
        flush_pc = 32'h0;
        deq_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drains exp_q through the handshake, checking order, data and occupancy.
    task automatic drain(input int max_cycles, input bit toggle);
        logic [31:0] e;
        for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) begin
            deq_ready = toggle ? ((c % 2) == 0) : 1'b1;
            #1;
            chk("fq_count_le_depth", {31'h0, (fq_count <= 3'd4)}, 32'h1);
            if (deq_valid && deq_ready) begin
                e = exp_q.pop_front();
                chk("deq_pc", deq_pc, e);
                chk("deq_instr", deq_instr, mem[e[7:2]]);
            end
            @(posedge clk);
            #1;
        end
        chk("drain_complete", exp_q.size(), 32'h0);
        deq_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        flush_pc = 32'h0;
        deq_ready = 1'b0;

        // ---- Table: sequential fetch, halt, flush from halt ----
        for (int i = 0; i < 64; i++) mem[i] = 32'h2222_2222;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0000_0000;

        vt[0]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[1]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[2]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[3]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'h0050_0093, 3'd1, 1'b0);
        vt[4]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h4, 32'h0010_0113, 3'd1, 1'b0);
        vt[5]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[6]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b1);
        vt[7]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b1);
        vt[8]  = mk(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b1);
        vt[9]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[10] = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[11] = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'h0050_0093, 3'd1, 1'b0);
        vt[12] = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h4, 32'h0010_0113, 3'd1, 1'b0);
        vt[13] = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b0);
        vt[14] = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0, 1'b1);

        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            rst_n     = vt[i].rst_n;
            flush     = vt[i].flush;
            flush_pc  = vt[i].flush_pc;
            deq_ready = vt[i].ready;
            #1;
            chk($sformatf("row%0d_imem_req", i),  {31'h0, imem_req},  {31'h0, vt[i].req});
            chk($sformatf("row%0d_imem_addr", i), imem_addr,          vt[i].addr);
            chk($sformatf("row%0d_deq_valid", i), {31'h0, deq_valid}, {31'h0, vt[i].valid});
            chk($sformatf("row%0d_deq_pc", i),    deq_pc,             vt[i].pc);
            chk($sformatf("row%0d_deq_instr", i), deq_instr,          vt[i].instr);
            chk($sformatf("row%0d_fq_count", i),  {29'h0, fq_count},  {29'h0, vt[i].count});
            chk($sformatf("row%0d_halted", i),    {31'h0, halted},    {31'h0, vt[i].halted});
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        // ---- Backpressure: queue fills to 4, requests stop, order kept ----
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i + 1;
        reset_dut();
        repeat (8) tick();
        #1;
        chk("bp_count_full", {29'h0, fq_count}, 32'd4);
        chk("bp_req_off",    {31'h0, imem_req}, 32'd0);
        chk("bp_head_pc",    deq_pc,            32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        drain(40, 1'b0);

        // ---- Flush mid-stream with count=3 and a response in flight ----
        reset_dut();
        repeat (4) tick();
        flush = 1'b1;
        flush_pc = 32'h40;
        #1;
        chk("fl_count_before", {29'h0, fq_count}, 32'd3);
        chk("fl_no_req",       {31'h0, imem_req}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_count_cleared", {29'h0, fq_count}, 32'd0);
        chk("fl_valid_low",     {31'h0, deq_valid}, 32'd0);
        chk("fl_req_restart",   {31'h0, imem_req}, 32'd1);
        chk("fl_addr_restart",  imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        drain(20, 1'b0);

        // ---- Reset mid-operation with count=2 ----
        reset_dut();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rs_count_before", {29'h0, fq_count}, 32'd2);
        tick();
        #1;
        chk("rs_req",    {31'h0, imem_req},  32'd0);
        chk("rs_addr",   imem_addr,          32'd0);
        chk("rs_valid",  {31'h0, deq_valid}, 32'd0);
        chk("rs_pc",     deq_pc,             32'd0);
        chk("rs_instr",  deq_instr,          32'd0);
        chk("rs_count",  {29'h0, fq_count},  32'd0);
        chk("rs_halted", {31'h0, halted},    32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        drain(20, 1'b0);

        // ---- Toggling ready over 10 instructions, wrap and halt ----
        for (int i = 0; i < 64; i++) mem[i] = 32'h3333_3333;
        for (int i = 0; i < 10; i++) mem[i] = 32'h0000_1000 + i * 32'h11;
        mem[10] = 32'h0;
        reset_dut();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        drain(200, 1'b1);
        deq_ready = 1'b1;
        for (int c = 0; c < 10 && !halted; c++) tick();
        #1;
        chk("tg_halted",  {31'h0, halted},    32'd1);
        chk("tg_count",   {29'h0, fq_count},  32'd0);
        chk("tg_req_off", {31'h0, imem_req},  32'd0);
        chk("tg_valid",   {31'h0, deq_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
